tile_ram_arbiter: RTL
=====================

Name: tile_ram_arbiter

Overview:
- Shares one single-port synchronous tile-map RAM (maze/pellet tiles) between two requesters.
- Requester 1 is the pixel renderer, driven by the 640x480 scan counters; it has strict priority and a fixed 1-cycle latency.
- Requester 2 is the game logic (Pac-Man/ghost moves, pellet erasure). It is buffered in a small in-order request queue and drained only in cycles the renderer leaves free.
- Sits between the scan/render path and the tile RAM, in the 50 MHz Clk domain.

Parameters:
- ADDR_W, 10, tile RAM address width.
- DATA_W, 8, tile RAM data width.
- QDEPTH, 4, game request queue depth (power of 2, >=2).
- STALL_W, 8, width of the saturating game-stall counter.

Ports:
- Clk  in  1  50 MHz system clock
- Reset  in  1  asynchronous, active-high reset
- ren_req  in  1  renderer read request this cycle
- ren_addr  in  ADDR_W  renderer read address
- ren_rvalid  out  1  renderer read data valid
- ren_rdata  out  DATA_W  renderer read data
- vblank  in  1  high while the scan line is >=480
- game_valid  in  1  game request valid
- game_ready  out  1  queue can accept a request
- game_we  in  1  1 = write, 0 = read
- game_addr  in  ADDR_W  game address
- game_wdata  in  DATA_W  game write data
- game_rvalid  out  1  game read data valid (1-cycle pulse)
- game_rdata  out  DATA_W  game read data
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address
- stall_cnt  out  STALL_W  saturating count of cycles the queue was non-empty but not granted
- q_level  out  $clog2(QDEPTH)+1  current queue occupancy

Behaviour:
- Reset values: game_ready=1 after reset; ren_rvalid=0, game_rvalid=0, ram_we=0, ram_addr=0, stall_cnt=0, q_level=0; queue flushed.
- Reset asserted mid-operation discards queued requests and any in-flight read data (no rvalid pulse follows).
- Handshake:
  - Push when game_valid && game_ready.
  - game_ready = !full.
  - Push and pop in the same cycle are allowed when not full; q_level is unchanged.
  - When full, ready=0 and game_valid is ignored.
  - The requester holds its signals until accepted.
- Grant state machine, registered grant state G in {IDLE, REN, GAME}, evaluated every Clk:
  - ren_req=1 -> G=REN: ram_addr=ren_addr, ram_we=0.
  - ren_req=0 and queue non-empty -> G=GAME: pop head; drive ram_addr, ram_we=head.we, ram_wdata=head.wdata.
  - Otherwise G=IDLE: ram_we=0, ram_addr holds its last value.
- RAM port outputs are combinational from the grant decision; the read-return tag is registered.
- Latency:
  - ren_rvalid asserts exactly 1 cycle after a REN grant, with ren_rdata=ram_rdata.
  - game_rvalid asserts 1 cycle after a GAME grant of a read (we=0). A write produces no rvalid.
  - rdata outputs hold their last value when valid=0.
- Ordering: game requests are serviced strictly in FIFO order. A read queued after a write to the same address returns the written data.
- Empty-to-grant latency: a request pushed at cycle t is at the earliest granted at t+1.
- stall_cnt:
  - Increments each cycle the queue is non-empty and the grant is not GAME.
  - Saturates at 2^STALL_W-1.
  - Clears only on Reset.
- Renderer is never delayed and never sees backpressure.

Optional Feature:
- Macro VBLANK_ONLY_EN.
- Defined: a GAME grant additionally requires vblank=1, so game writes never tear the visible frame. Queued requests wait through active display, and stall_cnt counts those cycles.
- Undefined: vblank is ignored, and GAME is granted in any renderer-idle cycle.

Test Plan:
- Renderer only: ren_req=1 with addr 0x005; RAM model preloaded 0x005=0x3C -> next cycle ren_rvalid=1, ren_rdata=0x3C. game_rvalid stays 0.
- Priority and stall: game writes 0x010<-0xAA while ren_req is held 1 for 3 cycles -> ram_we stays 0 for 3 cycles and stall_cnt=3. In the cycle ren_req drops, ram_we=1, ram_addr=0x010, ram_wdata=0xAA.
- Ordering: push write 0x020<-0x55, then read 0x020, with ren_req=0 -> write and read granted on consecutive cycles. game_rvalid pulses once with game_rdata=0x55.
- Full queue: push 4 requests with ren_req=1 continuously -> q_level=4, game_ready=0, and a 5th game_valid is not accepted. Release ren_req -> 4 grants on 4 consecutive cycles, then game_ready=1.
- Reset mid-op: 3 queued requests plus an in-flight game read, then assert Reset for 1 cycle -> q_level=0, no game_rvalid, stall_cnt=0, no further RAM writes.
- VBLANK_ONLY_EN defined: queued write, ren_req=0, vblank=0 for 10 cycles -> no grant, stall_cnt=10. Raise vblank -> grant the next cycle.

Source files
------------

// File: rtl/tile_ram_arbiter.sv
// tile_ram_arbiter: shares one single-port synchronous tile RAM between the pixel
//   renderer (strict priority) and the game logic (buffered in an in-order queue).
// Latency: RAM port is driven combinationally in the grant cycle; read data returns
//   exactly 1 cycle after a grant. Game requests wait at least 1 cycle in the queue.
// Backpressure: the renderer never stalls; the game side sees game_ready=0 only while
//   its QDEPTH-entry queue is full.
// Optional build macro: VBLANK_ONLY_EN - game grants additionally require vblank=1.
// Ports:
//   Clk, Reset                  clock, asynchronous active-high reset
//   ren_req/ren_addr            renderer read request (granted every cycle it is high)
//   ren_rvalid/ren_rdata        renderer read return (rdata holds when rvalid=0)
//   vblank                      vertical blank indicator (only used with VBLANK_ONLY_EN)
//   game_valid/ready/we/addr/wdata  game request handshake into the queue
//   game_rvalid/game_rdata      game read return, 1-cycle pulse (rdata holds otherwise)
//   ram_addr/we/wdata/rdata     tile RAM port (rdata valid the cycle after the address)
//   stall_cnt                   saturating count of cycles the queue waited for a grant
//   q_level                     current queue occupancy

// Small generic show-ahead FIFO: dout always presents the head entry.
// Push is ignored when full, pop is ignored when empty.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   push,
   input  logic [W-1:0]           din,
   input  logic                   pop,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge Clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign level = count;
endmodule

module tile_ram_arbiter #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 8,
   parameter int QDEPTH  = 4,
   parameter int STALL_W = 8
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      ren_req,
   input  logic [ADDR_W-1:0]         ren_addr,
   output logic                      ren_rvalid,
   output logic [DATA_W-1:0]         ren_rdata,
   input  logic                      vblank,
   input  logic                      game_valid,
   output logic                      game_ready,
   input  logic                      game_we,
   input  logic [ADDR_W-1:0]         game_addr,
   input  logic [DATA_W-1:0]         game_wdata,
   output logic                      game_rvalid,
   output logic [DATA_W-1:0]         game_rdata,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic                      ram_we,
   output logic [DATA_W-1:0]         ram_wdata,
   input  logic [DATA_W-1:0]         ram_rdata,
   output logic [STALL_W-1:0]        stall_cnt,
   output logic [$clog2(QDEPTH):0]   q_level
);
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } greq_t;

   typedef enum logic [1:0] {
      G_IDLE = 2'd0,
      G_REN  = 2'd1,
      G_GAME = 2'd2
   } gnt_t;

   gnt_t              g_q;
   gnt_t              g_nxt;
   greq_t             push_req;
   greq_t             head;
   logic              q_full;
   logic              q_empty;
   logic              q_pop;
   logic              game_ok;
   logic              rd_tag_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] ren_rdata_q;
   logic [DATA_W-1:0] game_rdata_q;

   assign push_req = {game_we, game_addr, game_wdata};

   sync_fifo #(
      .W     ($bits(greq_t)),
      .DEPTH (QDEPTH)
   ) u_q (
      .Clk   (Clk),
      .Reset (Reset),
      .push  (game_valid),
      .din   (push_req),
      .pop   (q_pop),
      .dout  (head),
      .full  (q_full),
      .empty (q_empty),
      .level (q_level)
   );

   // Ready depends only on occupancy, so a same-cycle pop never opens a full queue.
   assign game_ready = !q_full;

`ifdef VBLANK_ONLY_EN
   // Game traffic (notably pellet erasure) is held off during active display.
   assign game_ok = vblank;
`else
   logic unused_vblank;
   assign unused_vblank = vblank;
   assign game_ok       = 1'b1;
`endif

   // Grant state register; rd_tag_q marks a game read whose data returns next cycle.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         g_q      <= G_IDLE;
         rd_tag_q <= 1'b0;
      end else begin
         g_q      <= g_nxt;
         rd_tag_q <= (g_nxt == G_GAME) && !head.we;
      end
   end

   // Next grant: renderer first, then the queue head.
   always_comb begin
      g_nxt = G_IDLE;
      if (ren_req) begin
         g_nxt = G_REN;
      end else if (!q_empty && game_ok) begin
         g_nxt = G_GAME;
      end
   end

   // RAM port follows the grant decision in the same cycle; IDLE keeps the last address.
   always_comb begin
      ram_addr  = addr_q;
      ram_we    = 1'b0;
      ram_wdata = '0;
      q_pop     = 1'b0;
      case (g_nxt)
         G_REN: begin
            ram_addr = ren_addr;
         end
         G_GAME: begin
            ram_addr  = head.addr;
            ram_we    = head.we;
            ram_wdata = head.wdata;
            q_pop     = 1'b1;
         end
         default: ;
      endcase
   end

   assign ren_rvalid  = (g_q == G_REN);
   assign game_rvalid = rd_tag_q;
   assign ren_rdata   = ren_rvalid  ? ram_rdata : ren_rdata_q;
   assign game_rdata  = game_rvalid ? ram_rdata : game_rdata_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         addr_q       <= '0;
         ren_rdata_q  <= '0;
         game_rdata_q <= '0;
         stall_cnt    <= '0;
      end else begin
         addr_q <= ram_addr;
         if (ren_rvalid) begin
            ren_rdata_q <= ram_rdata;
         end
         if (game_rvalid) begin
            game_rdata_q <= ram_rdata;
         end
         if (!q_empty && (g_nxt != G_GAME) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end
endmodule
